regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-cycle 32x32 register file, for the pipelined datapath.
- Provides a DEPTH x DATA_WIDTH register array with two asynchronous read ports and one synchronous write port.
- Adds a per-register pending (scoreboard) bit with an occupancy counter, so hazard logic can stall on registers still awaiting writeback.
- Sits between the ID stage (reads, issue) and the WB stage (writes, clearing pending).

Parameters:
DATA_WIDTH, 32, width of each register and data port.
ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH.
ZERO_REG, 1, when 1 register 0 is hardwired to zero and never pending; when 0 register 0 is an ordinary register.

Ports:
Clk  in  1  clock; all state updates on the rising edge.
Reset  in  1  synchronous, active-high reset.
ReadRegister1  in  ADDR_WIDTH  read port 1 address.
ReadRegister2  in  ADDR_WIDTH  read port 2 address.
ReadData1  out  DATA_WIDTH  read port 1 data, combinational.
ReadData2  out  DATA_WIDTH  read port 2 data, combinational.
ReadBusy1  out  1  ReadRegister1 is pending, combinational.
ReadBusy2  out  1  ReadRegister2 is pending, combinational.
RegWrite  in  1  write enable (WB stage).
WriteRegister  in  ADDR_WIDTH  write address.
WriteData  in  DATA_WIDTH  write data.
IssueValid  in  1  marks IssueRegister as pending (ID stage issue of a producer).
IssueRegister  in  ADDR_WIDTH  destination register being issued.
PendingCount  out  ADDR_WIDTH+1  number of registers currently pending, registered.

Behaviour:
- Reset (synchronous, active-high):
  - Takes priority over any write or issue in the same cycle.
  - At the next rising edge: all registers become 0, all pending bits 0, PendingCount 0.
  - After reset: ReadData1/2 = 0 and ReadBusy1/2 = 0 for every address.
- Write:
  - When RegWrite=1, reg[WriteRegister] <= WriteData at the rising edge.
  - Without bypass, read ports see the new value from the following cycle.
  - With ZERO_REG=1, a write to address 0 is ignored and reads of address 0 return 0.
- Issue:
  - When IssueValid=1, pending[IssueRegister] <= 1 at the rising edge.
  - With ZERO_REG=1, an issue to address 0 is ignored.
- Writeback clear: when RegWrite=1, pending[WriteRegister] <= 0 at the rising edge.
- Issue and write to the same register in the same cycle: set wins, the register stays or becomes pending. This models a new producer issued while an older one retires.
- Writing a non-pending register is legal; pending stays 0.
- Issuing an already-pending register is legal; pending stays 1 and the count is unchanged.
- PendingCount, updated each edge:
  - +1 if an issue sets a previously clear bit.
  - -1 if a write clears a previously set bit.
  - Both on different registers: net 0.
  - Same register (set wins): +1 if previously clear, 0 if previously set.
  - Never exceeds DEPTH (DEPTH-1 with ZERO_REG=1); never wraps below 0.
- Both read ports may address the same register; both return identical data and busy values.
- Latency:
  - Reads: 0 cycles (combinational).
  - Writes, issue and pending updates: visible 1 cycle after the edge.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - If RegWrite=1 and WriteRegister equals ReadRegisterN (and is not hardwired zero), ReadDataN = WriteData in the same cycle.
  - ReadBusyN = 0 in that cycle unless IssueValid targets the same register.
  - Implements write-before-read within one cycle, as the pipeline requires.
- Undefined: reads return only stored array contents; ReadBusyN reflects the stored pending bit only.

Test Plan:
- Reset then read all 32 addresses -> every ReadData = 0, ReadBusy = 0, PendingCount = 0.
- Write 0xA5A5_0008..0xA5A5_0019 into r8..r25, then read pairs (r8,r9), (r10,r11), ... -> each returns its written value; write 0xFFFF_FFFF to r0 -> r0 reads 0.
- Issue r3, then r4 on consecutive cycles -> ReadBusy1=1 for r3, PendingCount=2; write r3=3 -> busy cleared next cycle, PendingCount=1, ReadData1=3.
- In the same cycle, IssueValid on r5 (already pending) with RegWrite on r5 -> r5 stays pending, count unchanged; issue r6 with write r4 -> count unchanged, r6 busy, r4 not busy.
- Assert Reset while r7 is pending and RegWrite targets r7 = 7 -> next cycle r7 = 0, not busy, PendingCount = 0.
- With REGFILE_WRITE_BYPASS_EN: write r2 = 0x1234 while ReadRegister2 = 2 -> ReadData2 = 0x1234 and ReadBusy2 = 0 in that same cycle. Without the macro -> old value that cycle, 0x1234 the next.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   DEPTH x DATA_WIDTH register file for the pipelined datapath. It has two
//   asynchronous read ports and one synchronous write port. A per-register
//   pending (scoreboard) bit and an occupancy counter let the hazard logic
//   stall on registers that are still waiting for writeback.
//
// Ports
//   Clk            rising-edge clock for all state
//   Reset          synchronous, active-high; beats any write/issue that cycle
//   ReadRegister1  read port 1 address  -> ReadData1 / ReadBusy1 (combinational)
//   ReadRegister2  read port 2 address  -> ReadData2 / ReadBusy2 (combinational)
//   RegWrite       WB-stage write enable; also clears the pending bit
//   WriteRegister  write address
//   WriteData      write data
//   IssueValid     ID-stage issue of a producer; sets the pending bit
//   IssueRegister  destination register being issued
//   PendingCount   registered count of pending registers
//
// Optional feature
//   REGFILE_WRITE_BYPASS_EN : when defined, a same-cycle write to a register
//   being read is forwarded to the read port. Its busy flag is then cleared
//   unless the same register is being issued in that cycle.

module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic                  ReadBusy1,
  output logic                  ReadBusy2,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  IssueValid,
  input  logic [ADDR_WIDTH-1:0] IssueRegister,
  output logic [ADDR_WIDTH:0]   PendingCount
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      pending;
  logic [DEPTH-1:0]      pendingNext;
  logic [CW-1:0]         pendingCount;
  logic [CW-1:0]         countNext;

  logic writeEn;
  logic issueEn;
  logic setsNew;
  logic clearsOld;

  // True for the hardwired-zero register. Reads of it return 0, and writes
  // and issues to it are dropped.
  function automatic logic isHardZero(input logic [ADDR_WIDTH-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Qualified write/issue enables, and the counter deltas. The counter is
  // adjusted incrementally rather than by a popcount. It only moves when a
  // bit actually changes state. When a set and a clear hit the same register,
  // the set wins, so that case never counts as a clear.
  always_comb begin
    writeEn   = RegWrite && !isHardZero(WriteRegister);
    issueEn   = IssueValid && !isHardZero(IssueRegister);
    setsNew   = issueEn && !pending[IssueRegister];
    clearsOld = writeEn && pending[WriteRegister]
                && !(issueEn && (IssueRegister == WriteRegister));
    countNext = pendingCount + CW'(setsNew) - CW'(clearsOld);
  end

  // Next pending vector. The writeback clear is applied first so that a
  // same-register issue overrides it.
  always_comb begin
    pendingNext = pending;
    if (writeEn) begin
      pendingNext[WriteRegister] = 1'b0;
    end
    if (issueEn) begin
      pendingNext[IssueRegister] = 1'b1;
    end
  end

  // Register array storage. Reset clears every entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEn) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  // Scoreboard state: pending bits and their occupancy count.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending      <= '0;
      pendingCount <= '0;
    end else begin
      pending      <= pendingNext;
      pendingCount <= countNext;
    end
  end

  assign PendingCount = pendingCount;

  // Read port 1. With bypass enabled, a write landing on this address in
  // the same cycle is forwarded, and busy then reflects only a concurrent
  // issue to the same register.
  always_comb begin
    ReadData1 = regs[ReadRegister1];
    ReadBusy1 = pending[ReadRegister1];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (writeEn && (WriteRegister == ReadRegister1)) begin
      ReadData1 = WriteData;
      ReadBusy1 = issueEn && (IssueRegister == ReadRegister1);
    end
`endif
    if (isHardZero(ReadRegister1)) begin
      ReadData1 = '0;
      ReadBusy1 = 1'b0;
    end
  end

  // Read port 2: identical behaviour to port 1.
  always_comb begin
    ReadData2 = regs[ReadRegister2];
    ReadBusy2 = pending[ReadRegister2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (writeEn && (WriteRegister == ReadRegister2)) begin
      ReadData2 = WriteData;
      ReadBusy2 = issueEn && (IssueRegister == ReadRegister2);
    end
`endif
    if (isHardZero(ReadRegister2)) begin
      ReadData2 = '0;
      ReadBusy2 = 1'b0;
    end
  end

endmodule
